data_memory_bytelane: RTL

Parametrised successor to the processor's word data memory. Serves MIPS load/store traffic with byte, halfword and word access. Provides sign/zero extension on loads, alignment and range checking, a registered read port with a valid strobe, and a self-clearing init sweep after reset. Sits between the execute/memory pipeline stage and writeback.

---
 rtl/data_memory_bytelane_pkg.sv | 22 ++
 rtl/data_memory_bytelane_if.sv | 45 ++++
 rtl/dmem_load_align.sv | 38 +++
 rtl/data_memory_bytelane.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/data_memory_bytelane_pkg.sv
// Shared types and helpers for the byte-lane data memory.
// Size encodings, controller states and index-width math.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// Load/store request bus between the memory stage and the data memory.
// The master issues requests; the slave answers loads and errors.
interface data_memory_bytelane_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic                  rdata_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  err;

  modport master (
    output req_valid,
    output req_write,
    output req_size,
    output req_unsigned,
    output address,
    output data_in,
    input  ready,
    input  rdata_valid,
    input  data_out,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_size,
    input  req_unsigned,
    input  address,
    input  data_in,
    output ready,
    output rdata_valid,
    output data_out,
    output err
  );

endinterface

// File: rtl/dmem_load_align.sv
// Load path: lane select, shift to bit 0, sign/zero extension.
// Purely combinational; illegal sizes yield zero.
module dmem_load_align
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int OFF_W      = clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [OFF_W-1:0]      i_off,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_sgn_b;
  logic                  w_sgn_h;

  assign w_shift = i_word >> {i_off, 3'b000};
  assign w_sgn_b = ~i_unsigned & w_shift[7];
  assign w_sgn_h = ~i_unsigned & w_shift[15];

  always_comb begin
    o_data = '0;
    unique case (1'b1)
      (i_size == SIZE_BYTE):
        o_data = {{(DATA_WIDTH-8){w_sgn_b}}, w_shift[7:0]};
      (i_size == SIZE_HALF):
        o_data = {{(DATA_WIDTH-16){w_sgn_h}}, w_shift[15:0]};
      (i_size == SIZE_WORD):
        o_data = i_word;
      default:
        o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory with checked loads/stores and a
// post-reset clear sweep; loads return one cycle after acceptance.
module data_memory_bytelane
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH_WORDS    = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  data_memory_bytelane_if.slave bus
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF_W = clog2(LANES);
  localparam int IDX_W = clog2(DEPTH_WORDS);
  localparam int TOP_B = IDX_W + OFF_W;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic                  w_ready;
  logic                  w_sweep;

  logic                  r_rvalid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [OFF_W-1:0]      w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_mis;
  logic                  w_ill;
  logic                  w_bad;
  logic                  w_acc;
  logic [LANES-1:0]      w_mask;
  logic [DATA_WIDTH-1:0] w_rep;

  logic                  w_we;
  logic [IDX_W-1:0]      w_widx;
  logic [LANES-1:0]      w_wmask;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_ld_data;

  assign w_off = bus.address[OFF_W-1:0];
  assign w_idx = bus.address[TOP_B-1:OFF_W];
  assign w_oor = |bus.address[ADDR_WIDTH-1:TOP_B];
  assign w_ill = (bus.req_size == SIZE_ILLEGAL);
  assign w_bad = w_ill | w_mis | w_oor;
  assign w_acc = w_ready & bus.req_valid;

  // Store data is replicated so any lane picked by the mask sees it.
  always_comb begin
    w_mask = '0;
    w_rep  = '0;
    w_mis  = 1'b0;
    unique case (1'b1)
      (bus.req_size == SIZE_BYTE): begin
        w_mask = LANES'(1) << w_off;
        w_rep  = {LANES{bus.data_in[7:0]}};
      end
      (bus.req_size == SIZE_HALF): begin
        w_mask = LANES'(3) << w_off;
        w_rep  = {(LANES/2){bus.data_in[15:0]}};
        w_mis  = w_off[0];
      end
      (bus.req_size == SIZE_WORD): begin
        w_mask = '1;
        w_rep  = bus.data_in;
        w_mis  = |w_off;
      end
      default: begin
        w_mask = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ready     = 1'b0;
    w_sweep     = 1'b0;
    unique case (r_state)
      INIT: begin
        if (CLEAR_ON_RESET) begin
          w_sweep   = 1'b1;
          w_ptr_nxt = r_ptr + IDX_W'(1);
          if (r_ptr == IDX_W'(DEPTH_WORDS - 1))
            w_state_nxt = RUN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: w_ready = 1'b1;
      default: w_state_nxt = INIT;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_idx;
    w_wmask = w_mask;
    w_wdata = w_rep;
    if (w_sweep) begin
      w_we    = 1'b1;
      w_widx  = r_ptr;
      w_wmask = '1;
      w_wdata = '0;
    end else if (w_acc & bus.req_write & ~w_bad) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_wmask[l])
          r_mem[w_widx][l*8 +: 8] <= w_wdata[l*8 +: 8];
      end
    end
  end

  assign w_rd_word = r_mem[w_idx];

  dmem_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .i_word     (w_rd_word),
    .i_off      (w_off),
    .i_size     (bus.req_size),
    .i_unsigned (bus.req_unsigned),
    .o_data     (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_rvalid <= w_acc & (w_bad | ~bus.req_write);
      if (w_acc & w_bad) begin
        r_err  <= 1'b1;
        r_dout <= '0;
      end else if (w_acc & ~bus.req_write) begin
        r_err  <= 1'b0;
        r_dout <= w_ld_data;
      end
    end
  end

  assign bus.ready       = w_ready;
  assign bus.rdata_valid = r_rvalid;
  assign bus.data_out    = r_dout;
  assign bus.err         = r_err;

endmodule
